// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel-buffer, encoder and control signals between the WS2812 frame controller and its environment.
interface ws2812_frame_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              dv;
    logic              ws_in;
    logic              pix_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic              data;
    logic              ws_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, dv, ws_in, pix_data,
        input  pix_rd, pix_addr, data, ws_out, busy, frame_done
    );

    modport slave (
        input  start, dv, ws_in, pix_data,
        output pix_rd, pix_addr, data, ws_out, busy, frame_done
    );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer feeding the WS2812 bit encoder: fetches GRB pixels, presents one bit per dv
// strobe MSB first, gates the LED line, then holds it low for the latch gap.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | line gated low, waiting for start
//   S_FETCH | first pixel read in flight, capture into shift register
//   S_ARM   | pixel loaded, waiting for dv to open the gate on bit 23
//   S_SEND  | shifting bits out on each dv, prefetching the next pixel
//   S_LATCH | line gated low, counting RESET_BITS dv strobes
module ws2812_frame_ctrl #(
    parameter int LED_NUM    = 64,
    parameter int ADDR_W     = 6,
    parameter int RESET_BITS = 300
) (
    input  logic              clk,
    input  logic              restn,
    ws2812_frame_ctrl_if.slave bus
);
    localparam int LCNT_W = $clog2(RESET_BITS + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(LED_NUM - 1);
    localparam logic [LCNT_W-1:0] LAST_LATCH = LCNT_W'(RESET_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ARM,
        S_SEND,
        S_LATCH
    } state_t;

    state_t            r_state;
    logic [23:0]       r_shift;
    logic [23:0]       r_hold;
    logic [4:0]        r_bit_idx;
    logic [ADDR_W-1:0] r_pix_idx;
    logic [LCNT_W-1:0] r_latch_cnt;
    logic              r_gate;
    logic              r_data;
    logic              r_pix_rd;
    logic [ADDR_W-1:0] r_pix_addr;
    logic              r_cap;
    logic              r_busy;
    logic              r_frame_done;

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_bit_idx    <= '0;
            r_pix_idx    <= '0;
            r_latch_cnt  <= '0;
            r_gate       <= 1'b0;
            r_data       <= 1'b0;
            r_pix_rd     <= 1'b0;
            r_pix_addr   <= '0;
            r_cap        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_rd     <= 1'b0;
            r_frame_done <= 1'b0;
            // pix_data is valid the cycle after the read strobe
            r_cap        <= r_pix_rd;
            if (r_cap) begin
                r_hold <= bus.pix_data;
            end

            case (r_state)
                S_IDLE: begin
                    r_gate <= 1'b0;
                    if (bus.start && !r_frame_done) begin
                        r_pix_rd   <= 1'b1;
                        r_pix_addr <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_cap) begin
                        r_shift <= bus.pix_data;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (bus.dv) begin
                        r_data    <= r_shift[23];
                        r_gate    <= 1'b1;
                        r_bit_idx <= 5'd23;
                        r_pix_idx <= '0;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.dv) begin
                        if (r_bit_idx != 5'd0) begin
                            r_shift   <= {r_shift[22:0], 1'b0};
                            r_data    <= r_shift[22];
                            r_bit_idx <= r_bit_idx - 5'd1;
                            // strobe lands in the first cycle of bit 0, leaving a full period to capture
                            if (r_bit_idx == 5'd1 && r_pix_idx != LAST_PIX) begin
                                r_pix_rd   <= 1'b1;
                                r_pix_addr <= r_pix_idx + 1'b1;
                            end
                        end else if (r_pix_idx == LAST_PIX) begin
                            r_gate      <= 1'b0;
                            r_data      <= 1'b0;
                            r_latch_cnt <= '0;
                            r_state     <= S_LATCH;
                        end else begin
                            r_shift   <= r_hold;
                            r_data    <= r_hold[23];
                            r_bit_idx <= 5'd23;
                            r_pix_idx <= r_pix_idx + 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    if (bus.dv) begin
                        if (r_latch_cnt == LAST_LATCH) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_latch_cnt  <= '0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_latch_cnt <= r_latch_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pix_rd     = r_pix_rd;
    assign bus.pix_addr   = r_pix_addr;
    assign bus.data       = r_data;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    // gate clears asynchronously with reset, so the line drops in the same instant
    assign bus.ws_out     = bus.ws_in & r_gate;
endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Upstream sequencer for the WS2812 bit-waveform encoder (247.5 MHz domain, 250-cycle bit period, `dv` pulse once per period).
- Fetches 24-bit GRB pixels from a pixel buffer and presents one bit per bit period on `data`, MSB first.
- Gates the encoder's `ws` line low outside active frames.
- After each frame, holds the line low for a latch (reset) gap, then reports completion.

Parameters:
- LED_NUM, 64, number of pixels per frame (1..2^ADDR_W).
- ADDR_W, 6, pixel buffer address width.
- RESET_BITS, 300, latch gap length in bit periods (300 × 250 cycles ≈ 303 µs).

Ports:
- clk  in  1  system clock, 247.5 MHz.
- restn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request; ignored unless in IDLE.
- dv  in  1  encoder bit-period strobe, 1 cycle high every 250 cycles.
- ws_in  in  1  encoder waveform output.
- pix_rd  out  1  pixel buffer read strobe.
- pix_addr  out  ADDR_W  pixel buffer read address.
- pix_data  in  24  pixel word, valid exactly 1 cycle after `pix_rd`; bit 23 is sent first.
- data  out  1  current bit to encoder.
- ws_out  out  1  LED line = ws_in AND gate (combinational; `gate` is an internal register).
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  1-cycle pulse at end of latch gap.

Behaviour:
- Reset is async and active-low. Reset values:
  - registered outputs: `data` = 0, `pix_rd` = 0, `pix_addr` = 0, `busy` = 0, `frame_done` = 0;
  - internal: `gate` = 0, so `ws_out` = 0;
  - state = IDLE; all counters = 0.
- States: IDLE → FETCH → ARM → SEND → LATCH → IDLE.
- IDLE:
  - `gate` = 0.
  - On `start`: `pix_rd` = 1 for 1 cycle with `pix_addr` = 0; go to FETCH.
- FETCH:
  - The cycle after `pix_rd`, capture `pix_data` into the shift register; go to ARM.
- ARM:
  - Wait for `dv`.
  - On `dv`: `data` <= shift[23], `gate` <= 1, bit index = 23, pixel index = 0; go to SEND.
  - `gate` rises on the same edge the encoder raises `ws`, so the first visible pulse is a full period.
- SEND, on each `dv`: advance to the next bit and update `data` on that edge.
  - Updating on `dv` is safe because the encoder's first 50 cycles are high for either bit value.
- Prefetch:
  - When bit index reaches 0 and pixel index < LED_NUM-1, issue `pix_rd` for pixel index+1 in that cycle.
  - Capture the result into a holding register 1 cycle later.
  - On the next `dv`, load the holding register into the shift register and present bit 23.
- End of frame:
  - On the `dv` that ends bit 0 of pixel LED_NUM-1: `gate` <= 0, `data` <= 0, clear the latch counter, go to LATCH.
  - No extra high pulse appears on `ws_out`.
- LATCH:
  - Count `dv` pulses.
  - On the RESET_BITS-th `dv`: `frame_done` = 1 for 1 cycle, go to IDLE.
- `start` outside IDLE is dropped; it is not queued.
- `start` in the same cycle that `frame_done` pulses is ignored; the controller accepts `start` from the next cycle.
- `dv` arriving during FETCH (same cycle as the capture) is not consumed; ARM waits for the next `dv`.
- Reset asserted mid-frame: `gate` clears immediately, forcing `ws_out` low; all state is abandoned.
- LED_NUM = 1: no prefetch is issued; the frame is 24 bits.
- Counter widths:
  - bit index: 5 bits;
  - pixel index: ADDR_W bits (no wrap inside a frame);
  - latch counter: ceil(log2(RESET_BITS+1)) bits.

Test Plan:
1. Single pixel: LED_NUM = 1, pix_data = 24'hA50000, free-running encoder.
   - `ws_out` shows bits 1,0,1,0,0,1,0,1 then 16 zeros.
   - Each '1' is high 200 cycles; each '0' is high 50 cycles.
   - Then low for 300×250 cycles, then `frame_done`.
2. Three pixels: buffer holds 24'hFFFFFF, 24'h000000, 24'h0F0F0F.
   - Exactly 3 `pix_rd` pulses, at addresses 0, 1, 2.
   - 72 contiguous bit periods with no gap or duplicated bit between pixels.
3. Gate alignment: `start` issued mid bit-period.
   - `ws_out` stays 0 until the first full period after ARM.
   - There are no partial pulses at the start or end of the frame.
4. `start` pulsed during SEND and during LATCH.
   - Ignored: no extra `pix_rd`, one `frame_done` per accepted start.
   - `busy` stays high throughout.
5. `restn` low for 3 cycles at bit 10 of pixel 1.
   - `ws_out` = 0 within 0 cycles of assertion; `busy` = 0.
   - A subsequent `start` replays the frame from pixel 0.
6. Back-to-back frames: `start` the cycle after `frame_done`.
   - Second frame begins, and the latch gap between frames measures exactly RESET_BITS periods low.
